// File: rtl/rr_mux_arb_if.sv
// Requester/consumer bundle for rr_mux_arb; the lock vector exists only when RR_ARB_LOCK_EN is defined.
interface rr_mux_arb_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    logic [N-1:0]    req;
    logic [N*DW-1:0] data;
    logic [N-1:0]    gnt;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_ready;
`ifdef RR_ARB_LOCK_EN
    logic [N-1:0]    lock;

    modport slave  (input  req, data, out_ready, lock, output gnt, out_valid, out_data);
    modport master (output req, data, out_ready, lock, input  gnt, out_valid, out_data);
`else
    modport slave  (input  req, data, out_ready, output gnt, out_valid, out_data);
    modport master (output req, data, out_ready, input  gnt, out_valid, out_data);
`endif
endinterface

// File: rtl/rr_mux_arb.sv
// Round-robin arbiter feeding one registered output stage from N requesters (optional lock: RR_ARB_LOCK_EN).
// Latency: req->gnt combinational, grant edge -> out_valid/out_data one cycle.
// Backpressure: output register holds and gnt stays 0 while out_valid & ~out_ready.
module rr_mux_arb #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_mux_arb_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] next_ptr;
    logic          found;
    logic          load_en;
    logic          grant_en;
    logic [N-1:0]  gnt_oh;
    logic [DW-1:0] sel_data;
    logic [DW-1:0] out_data_q;
    logic          out_valid_q;
    int            idx;

    assign load_en  = ~out_valid_q | bus.out_ready;
    assign grant_en = rst_n & load_en & found;

    // Scan starting at ptr, wrapping modulo N; first requester found wins.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                gidx  = PW'(idx);
            end
        end
    end

    always_comb begin
        gnt_oh   = '0;
        sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_en && gidx == PW'(k)) begin
                gnt_oh[k] = 1'b1;
                sel_data  = bus.data[k*DW +: DW];
            end
        end
    end

    always_comb begin
        next_ptr = (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
`ifdef RR_ARB_LOCK_EN
        // A locked winner keeps top priority for its next burst word.
        if (bus.lock[gidx]) next_ptr = gidx;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (load_en) begin
            if (found) begin
                out_data_q  <= sel_data;
                out_valid_q <= 1'b1;
                ptr         <= next_ptr;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.gnt       = gnt_oh;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Round-robin arbiter that shares one registered output stage between N requesters.
- The output stage is a mux-fed D register with a load enable.
- Each cycle it selects one requesting source, steers that source's data through the select mux into the output register, and returns a one-cycle grant.
- Sits between multiple producers and a single consumer that applies valid/ready backpressure.

Parameters:
- N, 4, number of requesters (2..16)
- DW, 8, data width per requester

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- req  input  N  request per requester; held high until granted
- data  input  N*DW  requester i data on bits [i*DW +: DW]
- gnt  output  N  combinational one-hot grant; transfer occurs on an edge where req[i] & gnt[i]
- out_valid  output  1  output register holds valid data
- out_data  output  DW  registered selected data
- out_ready  input  1  consumer accepts out_data on an edge where out_valid & out_ready

Behaviour:
- Reset (rst_n low at edge):
  - ptr = 0, so requester 0 has highest priority.
  - out_valid = 0, out_data = 0.
  - gnt is 0 while rst_n is low, since it is qualified combinationally by rst_n.
- load_en = ~out_valid | out_ready. This is the output register's mux select: hold when 0, load when 1.
- Arbitration, when load_en = 1 and |req:
  - gnt = one-hot of the first set req[k], scanning k = ptr, ptr+1, …, N-1, 0, …, ptr-1 (modulo N).
- When load_en = 0 or req = 0: gnt = 0.
- On an edge with a grant to k:
  - out_data <= data[k].
  - out_valid <= 1.
  - ptr <= (k+1) mod N. When k = N-1, wraps to 0.
- On an edge with load_en = 1 and no grant:
  - out_valid <= 0.
  - out_data holds its previous value (don't-care).
  - ptr unchanged.
- On an edge with load_en = 0 (stall):
  - out_valid, out_data and ptr all hold.
  - gnt is 0 throughout the stall.
- Latency: req to gnt is 0 cycles, combinational. Grant edge to out_valid is 1 cycle.
- Throughput: one transfer per cycle while out_ready stays high.
- Simultaneous consume and load: when out_valid & out_ready and a grant are on the same edge, the old word is consumed and the new word is loaded on that edge, with no bubble.
- Single active requester: granted every cycle that load_en = 1.
- All N requesting continuously: grants rotate 0,1,…,N-1,0,…. No requester waits more than N-1 grants.
- A requester that drops req before being granted is not granted. No state is kept for it.
- Reset mid-operation:
  - Any pending output word is discarded; out_valid is 0 after the edge.
  - ptr returns to 0.
  - Requesters must re-present req.
- gnt never has more than one bit set.
- gnt[i] is never set without req[i].

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- With the macro defined:
  - Adds input lock, width N.
  - If the granted requester k has lock[k] = 1 at the grant edge, ptr <= k instead of k+1. Requester k keeps top priority for back-to-back bursts.
  - The lock is released by deasserting lock[k] on a later grant, which advances ptr normally.
  - lock on a non-granted requester has no effect.
- Without the macro: no lock port; ptr always advances to k+1.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with req=4'b1111 -> gnt=0, out_valid=0, out_data=0 at each edge; first grant after release is gnt=4'b0001.
- Rotation: req=4'b1111, out_ready=1, data[i]=8'hA0+i, held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,…; out_data A0,A1,A2,A3,A0,…, each one cycle after its grant.
- Skip and wrap: ptr=2 after a grant to 1; then req=4'b0011 -> gnt=4'b0001 (wraps past 2,3); next req=4'b0011 -> gnt=4'b0010.
- Backpressure: out_valid=1, out_ready=0, req=4'b0100 for 3 cycles -> gnt=0 and out_data stable for 3 cycles. Raise out_ready -> gnt=4'b0100 the same cycle, and out_data=data[2] on the following cycle with no bubble.
- Idle: req=0 with out_ready=1 -> out_valid falls to 0 one cycle after the last transfer; ptr unchanged, so the next single req=4'b1000 is granted immediately.
- Lock (RR_ARB_LOCK_EN defined): req=4'b0011, lock=4'b0001 for 3 grants, then lock=0 -> gnt 0001,0001,0001,0001,0010. The fourth 0001 comes from the unlocked grant to 0, which then advances ptr to 1. Compiled without the macro, the same req gives 0001,0010,0001,0010.
